sprite_motion_engine: RTL
=========================

// Module: sprite_motion_engine
// PURPOSE
//  Per-frame motion controller for one player sprite: 4-way controls -> accelerated 2-D velocity,
//  bounded position, 8-way facing and wall-hit events. Sits between the control input decode and
//  the pixel-domain sprite renderer, which consumes x_pos/y_pos/facing as quasi-static per-frame values.
//  Successor to the fixed-speed driver: parametrised screen/sprite size, accel/decay, wall stun FSM.
// PARAMETERS
//  H_RES        640   visible width, pixels
//  V_RES        480   visible height, pixels
//  SPR_W        32    sprite width, pixels
//  SPR_H        32    sprite height, pixels
//  X_START      304   reset x (top-left corner)
//  Y_START      224   reset y (top-left corner)
//  MAX_VEL      4     velocity saturation magnitude, px/frame (< 2**(VEL_W-1))
//  ACCEL        1     velocity step per frame, accel and decay
//  VEL_W        5     signed velocity width
//  STUN_FRAMES  8     frames inputs are ignored after a wall hit (0 = no stun)
// PORTS
//  frame_clk  in   1      frame-rate clock, one update per rising edge
//  rst        in   1      reset, asynchronous, active-high
//  en         in   1      update enable; low = full freeze
//  controls   in   4      [0]=up [1]=left [2]=right [3]=down, level, synchronous to frame_clk
//  x_pos      out  11     sprite left edge, 0..H_RES-SPR_W
//  y_pos      out  11     sprite top edge, 0..V_RES-SPR_H
//  x_vel      out  VEL_W  signed x velocity, px/frame
//  y_vel      out  VEL_W  signed y velocity, px/frame
//  facing     out  3      0=N 1=NE 2=E 3=SE 4=S 5=SW 6=W 7=NW
//  wall_hit   out  4      1-frame pulse [0]=left [1]=right [2]=top [3]=bottom
//  state      out  2      0=IDLE 1=MOVE 2=STUN
// BEHAVIOUR
//  Reset: x_pos=X_START, y_pos=Y_START, vel=0, facing=0, wall_hit=0, state=IDLE, stun counter=0.
//  All outputs registered; all updates on frame_clk rising edge with en=1. en=0: every register
//  holds (incl. stun counter), wall_hit forced 0.
//  Effective input per axis: up&down or left&right -> none on that axis. Ignored entirely in STUN.
//  Velocity/axis: input -> vel +/- ACCEL toward input sign, saturate at +/-MAX_VEL; reversal ramps
//  through 0 at ACCEL/frame. No input -> decay toward 0 by ACCEL, never overshoot 0.
//  Position: next = pos + vel_current (12-bit signed math); vel updates same edge, so input at edge k
//  first moves the sprite at edge k+1.
//  Bounds: next<0 -> pos=0, wall_hit left/top; next>H_RES-SPR_W (V_RES-SPR_H) -> pos=limit,
//  wall_hit right/bottom. Exactly at limit = legal, no hit. Both axes may hit in same frame.
//  Hit axis velocity: set 0 (see CONFIGURATION). Non-hit axis follows normal rules.
//  FSM: IDLE -> MOVE on any effective input or nonzero vel. MOVE -> IDLE when no input and both vel
//   reach 0. Any hit with STUN_FRAMES>0 -> STUN, counter=STUN_FRAMES-1. STUN: decay only, counter
//   decrements; counter==0 -> MOVE if any vel nonzero else IDLE. Hit while in STUN reloads counter.
//  facing: updated from effective inputs in IDLE/MOVE (diagonal when both axes active); held when
//   no effective input and throughout STUN.
//  rst mid-frame/mid-stun: immediate return to reset values, counter cleared.
// CONFIGURATION
//  SPRITE_MOTION_BOUNCE_EN defined: on hit, axis vel = -vel_current (magnitude kept, position still
//   clamped); decay continues in STUN. Undefined: axis vel forced to 0 on hit.
// TESTING
//  1 rst pulse -> x=304 y=224 vel=0 facing=0 state=IDLE wall_hit=0.
//  2 hold right 5 edges -> x_vel 1,2,3,4,4; x_pos 304,305,307,310,314; facing=2; state=MOVE.
//  3 release after vel=4 -> x_vel 3,2,1,0,0; state IDLE once vel=0; facing stays 2.
//  4 x_pos=2, x_vel=-3, hold left -> x_pos=0, wall_hit=4'b0001 one frame, x_vel=0, STUN 8 frames,
//    left ignored during STUN, then MOVE resumes accel from 0. Bounce build: x_vel=+3 then decays.
//  5 up+down+right held -> y_vel stays 0, facing=2; up+left -> facing=7.
//  6 en=0 for 10 edges mid-motion/mid-stun -> all outputs and counter unchanged, wall_hit=0.

Source files
------------

// File: rtl/sprite_motion_engine.sv
// rtl/sprite_motion_engine.sv - per-frame sprite motion: accel/decay velocity, clamped position, facing, wall stun
// Optional: define SPRITE_MOTION_BOUNCE_EN to reflect the hit-axis velocity instead of zeroing it.
module sprite_motion_engine #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int SPR_W       = 32,
   parameter int SPR_H       = 32,
   parameter int X_START     = 304,
   parameter int Y_START     = 224,
   parameter int MAX_VEL     = 4,
   parameter int ACCEL       = 1,
   parameter int VEL_W       = 5,
   parameter int STUN_FRAMES = 8
) (
   input  logic                    frame_clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [3:0]              controls,
   output logic [10:0]             x_pos,
   output logic [10:0]             y_pos,
   output logic signed [VEL_W-1:0] x_vel,
   output logic signed [VEL_W-1:0] y_vel,
   output logic [2:0]              facing,
   output logic [3:0]              wall_hit,
   output logic [1:0]              state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_STUN = 2'd2} state_t;

   localparam int CNT_W = (STUN_FRAMES > 1) ? $clog2(STUN_FRAMES) : 1;
   localparam logic [CNT_W-1:0]      L_STUN_LOAD = CNT_W'((STUN_FRAMES > 0) ? STUN_FRAMES - 1 : 0);
   localparam logic signed [VEL_W:0] L_MAX = (VEL_W + 1)'(MAX_VEL);
   localparam logic signed [VEL_W:0] L_ACC = (VEL_W + 1)'(ACCEL);
   localparam logic signed [11:0]    L_X_LIM = 12'(H_RES - SPR_W);
   localparam logic signed [11:0]    L_Y_LIM = 12'(V_RES - SPR_H);

   logic [10:0]             r_x_pos, r_y_pos;
   logic signed [VEL_W-1:0] r_x_vel, r_y_vel;
   logic [2:0]              r_facing;
   logic [3:0]              r_wall_hit;
   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;

   // Direction codes: bit0 = positive axis direction, bit1 = negative; both clear = no input
   logic [1:0]              w_dx, w_dy;
   logic signed [11:0]      w_x_sum, w_y_sum;
   logic [3:0]              w_hit;
   logic [10:0]             w_x_pos_next, w_y_pos_next;
   logic signed [VEL_W-1:0] w_x_vel_next, w_y_vel_next;
   logic [2:0]              w_facing_next;
   state_t                  w_state_next;
   logic [CNT_W-1:0]        w_cnt_next;
   logic                    w_any_in, w_vel_nz;

   function automatic logic signed [VEL_W-1:0] f_vel_step(input logic signed [VEL_W-1:0] vel,
                                                          input logic [1:0] dir);
      logic signed [VEL_W:0] v;
      v = {vel[VEL_W-1], vel};
      case (dir)
         2'b01: begin
            v = v + L_ACC;
            if (v > L_MAX) v = L_MAX;
         end
         2'b10: begin
            v = v - L_ACC;
            if (v < -L_MAX) v = -L_MAX;
         end
         default: begin
            if (v > L_ACC)       v = v - L_ACC;
            else if (v < -L_ACC) v = v + L_ACC;
            else                 v = '0;
         end
      endcase
      return v[VEL_W-1:0];
   endfunction

   function automatic logic [2:0] f_facing(input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [2:0] cur);
      logic [2:0] f;
      case ({dy, dx})
         4'b1000: f = 3'd0;
         4'b1001: f = 3'd1;
         4'b0001: f = 3'd2;
         4'b0101: f = 3'd3;
         4'b0100: f = 3'd4;
         4'b0110: f = 3'd5;
         4'b0010: f = 3'd6;
         4'b1010: f = 3'd7;
         default: f = cur;
      endcase
      return f;
   endfunction

   always_comb begin
      w_dx = 2'b00;
      w_dy = 2'b00;
      if (r_state != S_STUN) begin
         w_dx = {controls[1] & ~controls[2], controls[2] & ~controls[1]};
         w_dy = {controls[0] & ~controls[3], controls[3] & ~controls[0]};
      end
   end

   assign w_x_sum = signed'({1'b0, r_x_pos}) + 12'(r_x_vel);
   assign w_y_sum = signed'({1'b0, r_y_pos}) + 12'(r_y_vel);
   assign w_hit   = {w_y_sum > L_Y_LIM, w_y_sum < 12'sd0, w_x_sum > L_X_LIM, w_x_sum < 12'sd0};

   assign w_x_pos_next = w_hit[0] ? 11'd0 : (w_hit[1] ? L_X_LIM[10:0] : w_x_sum[10:0]);
   assign w_y_pos_next = w_hit[2] ? 11'd0 : (w_hit[3] ? L_Y_LIM[10:0] : w_y_sum[10:0]);

`ifdef SPRITE_MOTION_BOUNCE_EN
   assign w_x_vel_next = (w_hit[0] | w_hit[1]) ? -r_x_vel : f_vel_step(r_x_vel, w_dx);
   assign w_y_vel_next = (w_hit[2] | w_hit[3]) ? -r_y_vel : f_vel_step(r_y_vel, w_dy);
`else
   assign w_x_vel_next = (w_hit[0] | w_hit[1]) ? '0 : f_vel_step(r_x_vel, w_dx);
   assign w_y_vel_next = (w_hit[2] | w_hit[3]) ? '0 : f_vel_step(r_y_vel, w_dy);
`endif

   assign w_any_in      = |{w_dx, w_dy};
   assign w_vel_nz      = (w_x_vel_next != '0) || (w_y_vel_next != '0);
   assign w_facing_next = f_facing(w_dx, w_dy, r_facing);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if ((|w_hit) && (STUN_FRAMES > 0)) begin
         w_state_next = S_STUN;
         w_cnt_next   = L_STUN_LOAD;
      end else begin
         case (r_state)
            S_IDLE: if (w_any_in || w_vel_nz) w_state_next = S_MOVE;
            S_MOVE: if (!w_any_in && !w_vel_nz) w_state_next = S_IDLE;
            S_STUN: begin
               if (r_cnt == '0) w_state_next = w_vel_nz ? S_MOVE : S_IDLE;
               else             w_cnt_next   = r_cnt - CNT_W'(1);
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge frame_clk or posedge rst) begin
      if (rst) begin
         r_x_pos    <= 11'(X_START);
         r_y_pos    <= 11'(Y_START);
         r_x_vel    <= '0;
         r_y_vel    <= '0;
         r_facing   <= 3'd0;
         r_wall_hit <= 4'd0;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
      end else if (en) begin
         r_x_pos    <= w_x_pos_next;
         r_y_pos    <= w_y_pos_next;
         r_x_vel    <= w_x_vel_next;
         r_y_vel    <= w_y_vel_next;
         r_facing   <= w_facing_next;
         r_wall_hit <= w_hit;
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
      end else begin
         r_wall_hit <= 4'd0;
      end
   end

   assign x_pos    = r_x_pos;
   assign y_pos    = r_y_pos;
   assign x_vel    = r_x_vel;
   assign y_vel    = r_y_vel;
   assign facing   = r_facing;
   assign wall_hit = r_wall_hit;
   assign state    = r_state;
endmodule
